// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC owner, imem address driver and {pc, instr} circular queue towards decode.
// Optional feature macro: STATIC_JUMP_EN (follow j/jal targets at fetch time).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          QPTR_W   = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    output logic        o_misalign_err,
    output logic [15:0] o_fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [QPTR_W:0] QFULL = (QPTR_W+1)'(QDEPTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_pc;
    logic [QPTR_W-1:0]   r_rd;
    logic [QPTR_W-1:0]   r_wr;
    logic [QPTR_W:0]     r_count;
    logic [QPTR_W:0]     w_count_next;
    logic [31:0]         r_q_pc    [QDEPTH];
    logic [31:0]         r_q_instr [QDEPTH];
    logic                r_misalign;
    logic [15:0]         r_fetch_count;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_pc_plus4;
    logic [31:0]         w_next_pc;

    // handshake and queue occupancy decisions for this cycle
    always_comb begin
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_count_next = r_count;
        if (i_redirect) begin
            w_count_next = '0;
        end else begin
            w_pop  = (r_count != '0) && i_out_ready;
            w_push = (r_state != ST_BOOT) && ((r_count < QFULL) || w_pop);
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + (QPTR_W+1)'(1);
                2'b01:   w_count_next = r_count - (QPTR_W+1)'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // sequential PC selection, optionally following static jumps
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
`ifdef STATIC_JUMP_EN
        if ((i_imem_data[31:26] == 6'b000010) || (i_imem_data[31:26] == 6'b000011)) begin
            w_next_pc = {w_pc_plus4[31:28], i_imem_data[25:0], 2'b00};
        end else begin
            w_next_pc = w_pc_plus4;
        end
`else
        w_next_pc = w_pc_plus4;
`endif
    end

    // FSM next-state; redirect always lands in RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  w_state_next = (w_count_next == QFULL) ? ST_HOLD : ST_RUN;
            ST_HOLD: w_state_next = w_pop ? ST_RUN : ST_HOLD;
            default: w_state_next = ST_BOOT;
        endcase
        if (i_redirect) begin
            w_state_next = ST_RUN;
        end else begin
            w_state_next = w_state_next;
        end
    end

    // control state: pc, pointers, counters, sticky error
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (i_redirect) begin
                r_pc <= {i_redirect_pc[31:2], 2'b00};
                r_rd <= '0;
                r_wr <= '0;
                if (i_redirect_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else begin
                if (w_push) begin
                    r_pc          <= w_next_pc;
                    r_wr          <= r_wr + QPTR_W'(1);
                    r_fetch_count <= r_fetch_count + 16'd1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + QPTR_W'(1);
                end
            end
        end
    end

    // queue storage; contents are masked by count so need no reset
    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_q_pc[r_wr]    <= r_pc;
            r_q_instr[r_wr] <= i_imem_data;
        end
    end

    assign o_imem_addr    = r_pc;
    assign o_out_valid    = (r_count != '0);
    assign o_out_instr    = o_out_valid ? r_q_instr[r_rd] : 32'h0000_0000;
    assign o_out_pc       = o_out_valid ? r_q_pc[r_rd] : 32'h0000_0000;
    assign o_misalign_err = r_misalign;
    assign o_fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; imem returns 0x1000_0000+addr unless jump mode plants j 0x40 at 0.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic [15:0] fetch_count;
    logic        jmode;

    int n_cmp;
    int n_err;

    fetch_unit dut (
        .i_clock        (clk),
        .i_reset        (reset),
        .o_imem_addr    (imem_addr),
        .i_imem_data    (imem_data),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_instr    (out_instr),
        .o_out_pc       (out_pc),
        .o_misalign_err (misalign_err),
        .o_fetch_count  (fetch_count)
    );

    assign imem_data = (jmode && imem_addr == 32'h0) ? 32'h0800_0010 : (32'h1000_0000 + imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        jmode       = 1'b0;

        // reset state
        step(); step();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_pc", out_pc, 32'h0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_mis", {31'd0, misalign_err}, 32'd0);
        check_eq("rst_fc", {16'd0, fetch_count}, 32'd0);

        // streaming with ready held high
        reset = 1'b0;
        check_eq("boot_addr", imem_addr, 32'h0);
        step();
        check_eq("boot_nopush", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("s_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("s_pc", out_pc, 32'(4 * i));
            check_eq("s_instr", out_instr, 32'h1000_0000 + 32'(4 * i));
            step();
        end

        // fill to HOLD, then drain with no bubble
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        check_eq("hold_addr", imem_addr, 32'h10);
        check_eq("hold_pc", out_pc, 32'h0);
        check_eq("hold_fc", {16'd0, fetch_count}, 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("drain_pc", out_pc, 32'(4 * i));
            if (i == 1) check_eq("drain_fc", {16'd0, fetch_count}, 32'd5);
            step();
        end

        // redirect from a full queue
        out_ready = 1'b0;
        step();
        check_eq("full_valid", {31'd0, out_valid}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check_eq("rd_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rd_addr", imem_addr, 32'h40);
        step();
        check_eq("rd_pc", out_pc, 32'h40);
        check_eq("rd_instr", out_instr, 32'h1000_0040);

        // misaligned redirect sets sticky error
        check_eq("pre_mis", {31'd0, misalign_err}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        check_eq("mis_addr", imem_addr, 32'h40);
        check_eq("mis_set", {31'd0, misalign_err}, 32'd1);
        step(); step(); step();
        check_eq("mis_sticky", {31'd0, misalign_err}, 32'd1);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_addr1", imem_addr, 32'h0);
        check_eq("wrap_pc", out_pc, 32'hFFFF_FFFC);

        // reset beats redirect with count=3
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst_mis_clr", {31'd0, misalign_err}, 32'd0);
        step();
        step(); step(); step();
        check_eq("c3_fc", {16'd0, fetch_count}, 32'd3);
        check_eq("c3_addr", imem_addr, 32'hC);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        step();
        reset = 1'b0; redirect = 1'b0;
        check_eq("rr_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rr_addr", imem_addr, 32'h0);
        check_eq("rr_fc", {16'd0, fetch_count}, 32'd0);
        step();
        check_eq("rr_boot_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rr_boot_addr", imem_addr, 32'h0);
        step();
        check_eq("rr_run_pc", out_pc, 32'h0);

        // static jump at address 0
        reset = 1'b1; jmode = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("j_head_pc", out_pc, 32'h0);
        check_eq("j_head_instr", out_instr, 32'h0800_0010);
`ifdef STATIC_JUMP_EN
        check_eq("j_next_addr", imem_addr, 32'h40);
`else
        check_eq("j_next_addr", imem_addr, 32'h4);
`endif
        step();
        out_ready = 1'b1;
        step();
`ifdef STATIC_JUMP_EN
        check_eq("j_second_pc", out_pc, 32'h40);
`else
        check_eq("j_second_pc", out_pc, 32'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
